// File: rtl/logic_gate_pipe_pkg.sv
// Shared definitions for the logic-unit blocks: operation codes and their width.
package logic_gate_pipe_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } gate_op_e;

endpackage

// File: rtl/logic_gate_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus WIDTH data bits, loaded on enable.
module gate_pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = v_in;
      data_d  = d_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign v_out = valid_q;
  assign d_out = data_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined bitwise logic unit: eight ops on two operands, STAGES-deep elastic
// pipeline with valid/ready on both sides, OR-reduction flag and saturating count.
module logic_gate_pipe
  import logic_gate_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_any,
  output logic [CNT_W-1:0] op_count
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  d [STAGES];
  logic [WIDTH-1:0]  op_res;
  gate_op_e          op_sel;
  logic              xfer;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  always_comb begin
    op_sel = gate_op_e'(in_op);
    op_res = '0;
    case (op_sel)
      OP_AND:    op_res = in_a & in_b;
      OP_OR:     op_res = in_a | in_b;
      OP_XOR:    op_res = in_a ^ in_b;
      OP_NAND:   op_res = ~(in_a & in_b);
      OP_NOR:    op_res = ~(in_a | in_b);
      OP_XNOR:   op_res = ~(in_a ^ in_b);
      OP_PASS_A: op_res = in_a;
      OP_NOT_A:  op_res = ~in_a;
      default:   op_res = '0;
    endcase
  end

  // The recursive advance chain is flattened: stage i may advance when the
  // sink is ready or any stage from i to the tail is empty.
  always_comb begin
    logic hole;
    adv = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      hole = 1'b0;
      for (int unsigned j = i; j < STAGES; j++) begin
        hole = hole | ~v[j];
      end
      adv[i] = hole | out_ready;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             v_src;
    logic [WIDTH-1:0] d_src;
    if (g == 0) begin : g_head
      assign v_src = in_valid;
      assign d_src = op_res;
    end else begin : g_body
      assign v_src = v[g-1];
      assign d_src = d[g-1];
    end
    gate_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (adv[g]),
      .v_in  (v_src),
      .d_in  (d_src),
      .v_out (v[g]),
      .d_out (d[g])
    );
  end

  assign xfer = v[STAGES-1] & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];
  assign out_s     = d[STAGES-1];
  assign out_any   = |d[STAGES-1];
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: vector table, hand sequences for
// stall/bubble/reset corners, and random traffic against a queue reference.
module tb_logic_gate_pipe;

  localparam int unsigned STAGES = 2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] s;
    logic       any;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       any;
    int         cyc;
  } item_t;

  logic       clk, rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_any;
  logic [7:0] in_a, in_b, out_s, op_count;
  logic [2:0] in_op;
  logic       in_ready_s, out_valid_s, out_any_s;
  logic [7:0] out_s_s;
  logic [1:0] op_count_s;

  logic_gate_pipe #(.WIDTH(8), .STAGES(STAGES), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_s(out_s), .out_any(out_any), .op_count(op_count)
  );

  logic_gate_pipe #(.WIDTH(8), .STAGES(STAGES), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_s(out_s_s), .out_any(out_any_s), .op_count(op_count_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         xfers = 0;
  bit         chk_lat = 0;
  logic       last_ix = 0;
  logic [7:0] pend_s;
  logic       pend_any;
  item_t      q[$];
  vec_t       vecs[10];

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Samples mid-cycle, checks against the queue reference, then advances one clock.
  task automatic tick();
    logic ix, ox;
    #4;
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    chk("in_ready", in_ready, (q.size() < STAGES) || out_ready);
    chk("out_any_red", out_any, |out_s);
    chk("op_count", op_count, (xfers > 255) ? 255 : xfers);
    chk("op_count_sat", op_count_s, (xfers > 3) ? 3 : xfers);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", out_valid, 0);
      end else begin
        chk("out_s", out_s, q[0].s);
        chk("out_any", out_any, q[0].any);
        if (ox && chk_lat) chk("latency", cyc - q[0].cyc, STAGES);
      end
    end
    if (ox) begin
      xfers++;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (ix) q.push_back('{s: pend_s, any: pend_any, cyc: cyc});
    last_ix = ix;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic present(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] s, input logic any);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    pend_s = s;
    pend_any = any;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [7:0] s;
    s = ref_op(a, b, op);
    present(a, b, op, s, |s);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_ix) break;
    end
    if (!last_ix) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain(input int limit);
    in_valid = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{8'hF0, 8'h3C, 3'd0, 8'h30, 1'b1};
    vecs[1] = '{8'hF0, 8'h3C, 3'd1, 8'hFC, 1'b1};
    vecs[2] = '{8'hF0, 8'h3C, 3'd2, 8'hCC, 1'b1};
    vecs[3] = '{8'hF0, 8'h3C, 3'd3, 8'hCF, 1'b1};
    vecs[4] = '{8'hF0, 8'h3C, 3'd4, 8'h03, 1'b1};
    vecs[5] = '{8'hF0, 8'h3C, 3'd5, 8'h33, 1'b1};
    vecs[6] = '{8'hF0, 8'h3C, 3'd6, 8'hF0, 1'b1};
    vecs[7] = '{8'hF0, 8'h3C, 3'd7, 8'h0F, 1'b1};
    vecs[8] = '{8'hAA, 8'h55, 3'd0, 8'h00, 1'b0};
    vecs[9] = '{8'hAA, 8'h55, 3'd1, 8'hFF, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    out_ready = 1'b1;
    pend_s = '0;
    pend_any = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_s", out_s, 8'h00);
    chk("rst_out_any", out_any, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // Back-to-back table vectors with the sink always ready.
    chk_lat = 1;
    foreach (vecs[i]) begin
      present(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].s, vecs[i].any);
      tick();
      chk("sweep_accept", last_ix, 1);
    end
    drain(STAGES + 3);
    chk_lat = 0;
    chk("sweep_count", op_count, 10);
    chk("sweep_sat", op_count_s, 3);

    // Backpressure: third op must wait until the sink drains.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd2);
    send(8'h56, 8'h78, 3'd1);
    chk("bp_full_ready", in_ready, 0);
    present(8'h9A, 8'hBC, 3'd0, 8'h98, 1'b1);
    repeat (3) begin
      tick();
      chk("bp_stall_ready", in_ready, 0);
      chk("bp_hold", out_s, 8'h26);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_ix) break;
    end
    chk("bp_late_accept", last_ix, 1);
    drain(10);

    // Bubble collapse: gap between two ops closes while the sink is stalled.
    out_ready = 1'b0;
    send(8'hC3, 8'h0F, 3'd0);
    in_valid = 1'b0;
    tick();
    tick();
    send(8'hC3, 8'h0F, 3'd1);
    in_valid = 1'b0;
    tick();
    chk("bubble_full", in_ready, 0);
    chk("bubble_head", out_s, 8'h03);
    out_ready = 1'b1;
    tick();
    chk("bubble_next_valid", out_valid, 1);
    chk("bubble_next_s", out_s, 8'hCF);
    drain(5);

    // Reset with two ops in flight and the sink stalled.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd1);
    send(8'h33, 8'h44, 3'd2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_s", out_s, 8'h00);
    chk("mid_rst_any", out_any, 0);
    chk("mid_rst_count", op_count, 0);
    chk("mid_rst_ready", in_ready, 1);
    q.delete();
    xfers = 0;
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      chk("no_stale", out_valid, 0);
    end

    // Random traffic; an offered op is held until accepted.
    last_ix = 0;
    for (int n = 0; n < 400; n++) begin
      if (last_ix || !in_valid) begin
        in_valid = 1'b0;
        if ($urandom_range(2) != 0) begin
          logic [7:0] a, b, s;
          logic [2:0] op;
          a = 8'($urandom);
          b = 8'($urandom);
          op = 3'($urandom);
          s = ref_op(a, b, op);
          present(a, b, op, s, |s);
        end
      end
      out_ready = ((n / 40) % 2 == 1) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      tick();
    end
    out_ready = 1'b1;
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
